// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the ARM-subset sequencing controller.
// Holds the FSM state type, condition codes, ALU opcodes and decode helpers.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      StFetch = 2'd0,
      StExec  = 2'd1,
      StWb    = 2'd2
   } state_e;

   localparam logic [3:0] CondEq = 4'h0;
   localparam logic [3:0] CondNe = 4'h1;
   localparam logic [3:0] CondCs = 4'h2;
   localparam logic [3:0] CondCc = 4'h3;
   localparam logic [3:0] CondMi = 4'h4;
   localparam logic [3:0] CondPl = 4'h5;
   localparam logic [3:0] CondVs = 4'h6;
   localparam logic [3:0] CondVc = 4'h7;
   localparam logic [3:0] CondHi = 4'h8;
   localparam logic [3:0] CondLs = 4'h9;
   localparam logic [3:0] CondGe = 4'hA;
   localparam logic [3:0] CondLt = 4'hB;
   localparam logic [3:0] CondGt = 4'hC;
   localparam logic [3:0] CondLe = 4'hD;
   localparam logic [3:0] CondAl = 4'hE;
   localparam logic [3:0] CondNv = 4'hF;

   localparam logic [3:0] OpAnd = 4'h0;
   localparam logic [3:0] OpEor = 4'h1;
   localparam logic [3:0] OpSub = 4'h2;
   localparam logic [3:0] OpRsb = 4'h3;
   localparam logic [3:0] OpAdd = 4'h4;
   localparam logic [3:0] OpAdc = 4'h5;
   localparam logic [3:0] OpSbc = 4'h6;
   localparam logic [3:0] OpRsc = 4'h7;
   localparam logic [3:0] OpTst = 4'h8;
   localparam logic [3:0] OpTeq = 4'h9;
   localparam logic [3:0] OpCmp = 4'hA;
   localparam logic [3:0] OpCmn = 4'hB;
   localparam logic [3:0] OpOrr = 4'hC;
   localparam logic [3:0] OpMov = 4'hD;
   localparam logic [3:0] OpBic = 4'hE;
   localparam logic [3:0] OpMvn = 4'hF;

   // Compare ops only update flags; they never write Rd.
   function automatic logic is_compare(input logic [3:0] op);
      return (op == OpTst) || (op == OpTeq) || (op == OpCmp) || (op == OpCmn);
   endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// Controller <-> datapath bundle: instruction/flags in, datapath controls out.
// master = controller side, slave = datapath side.
interface cpu_ctrl_if #(
   parameter int unsigned REG_AW = 4
);
   logic [31:0]       instr;
   logic [3:0]        flags;
   logic              waiting;
   logic [REG_AW-1:0] rf_ra;
   logic [REG_AW-1:0] rf_rb;
   logic [REG_AW-1:0] rf_wa;
   logic              rf_we;
   logic [3:0]        alu_op;
   logic              sel_imm;
   logic [11:0]       operand2;
   logic              ld_c;
   logic              ld_status;
   logic              illegal;
   logic [31:0]       retired;

   modport master (
      input  instr, flags,
      output waiting, rf_ra, rf_rb, rf_wa, rf_we, alu_op, sel_imm, operand2,
             ld_c, ld_status, illegal, retired
   );

   modport slave (
      output instr, flags,
      input  waiting, rf_ra, rf_rb, rf_wa, rf_we, alu_op, sel_imm, operand2,
             ld_c, ld_status, illegal, retired
   );
endinterface

// File: rtl/cond_check.sv
// ARM condition-field evaluation against NZCV ({N,Z,C,V}, bit 3 = N).
// Purely combinational; code 1111 is treated as never.
module cond_check
   import cpu_ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);
   logic n, z, c, v;

   assign n = flags[3];
   assign z = flags[2];
   assign c = flags[1];
   assign v = flags[0];

   always_comb begin
      pass = 1'b0;
      unique case (cond)
         CondEq: pass = z;
         CondNe: pass = !z;
         CondCs: pass = c;
         CondCc: pass = !c;
         CondMi: pass = n;
         CondPl: pass = !n;
         CondVs: pass = v;
         CondVc: pass = !v;
         CondHi: pass = c && !z;
         CondLs: pass = !c || z;
         CondGe: pass = (n == v);
         CondLt: pass = (n != v);
         CondGt: pass = !z && (n == v);
         CondLe: pass = z || (n != v);
         CondAl: pass = 1'b1;
         CondNv: pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end
endmodule

// File: rtl/cpu_controller.sv
// Three-cycle FETCH/EXEC/WB sequencer for data-processing instructions.
// Decodes ir, gates side effects on condition/legality, counts retired ops.
module cpu_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW = 4
) (
   input logic        clk,
   input logic        rst_n,
   cpu_ctrl_if.master bus
);
   state_e      state_q, state_d;
   logic [31:0] ir_q;
   logic        pass_q, legal_q, writing_q;
   logic [31:0] retired_q;

   logic pass, legal, writing, sets_flags;

   cond_check u_cond_check (
      .cond  (ir_q[31:28]),
      .flags (bus.flags),
      .pass  (pass)
   );

   assign writing    = !is_compare(ir_q[24:21]);
   assign sets_flags = ir_q[20] || is_compare(ir_q[24:21]);
   // Writing R15 would redirect the PC, which this datapath cannot do.
   assign legal      = (ir_q[27:26] == 2'b00) && !(writing && (ir_q[15:12] == 4'hF));

   assign bus.rf_ra    = REG_AW'(ir_q[19:16]);
   assign bus.rf_rb    = REG_AW'(ir_q[3:0]);
   assign bus.rf_wa    = REG_AW'(ir_q[15:12]);
   assign bus.alu_op   = ir_q[24:21];
   assign bus.sel_imm  = ir_q[25];
   assign bus.operand2 = ir_q[11:0];
   assign bus.retired  = retired_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StFetch;
         ir_q      <= '0;
         pass_q    <= 1'b0;
         legal_q   <= 1'b1;
         writing_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StFetch) begin
            ir_q <= bus.instr;
         end
         if (state_q == StExec) begin
            pass_q    <= pass;
            legal_q   <= legal;
            writing_q <= writing;
         end
         if ((state_q == StWb) && pass_q && legal_q) begin
            retired_q <= retired_q + 32'd1;
         end
      end
   end

   always_comb begin
      state_d       = StFetch;
      bus.waiting   = 1'b0;
      bus.ld_c      = 1'b0;
      bus.ld_status = 1'b0;
      bus.rf_we     = 1'b0;
      bus.illegal   = 1'b0;
      unique case (state_q)
         StFetch: begin
            state_d     = StExec;
            bus.waiting = 1'b1;
         end
         StExec: begin
            state_d       = StWb;
            bus.ld_c      = pass && legal;
            bus.ld_status = pass && legal && sets_flags;
         end
         StWb: begin
            state_d     = StFetch;
            bus.rf_we   = pass_q && legal_q && writing_q;
            bus.illegal = !legal_q;
         end
         default: state_d = StFetch;
      endcase
   end
endmodule

// File: tb/tb_cpu_controller.sv
// Directed table-driven bench for cpu_controller plus reset corner sequences.
module tb_cpu_controller;
   import cpu_ctrl_pkg::*;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   exp_retired;

   cpu_ctrl_if #(.REG_AW(4)) bus ();

   cpu_controller #(.REG_AW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  flags;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [3:0]  wa;
      logic [3:0]  op;
      logic        imm;
      logic [11:0] op2;
      logic        ld_c;
      logic        ld_status;
      logic        we;
      logic        ill;
      logic        inc;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Entered at a negedge in FETCH; leaves at the negedge of the next FETCH.
   task automatic run_vec(input vec_t t);
      bus.instr = t.instr;
      bus.flags = t.flags;
      chk("fetch_waiting", 32'(bus.waiting), 32'd1);
      @(negedge clk);
      bus.instr = 32'hFFFF_FFFF;  // changes after FETCH must be ignored
      chk("exec_waiting", 32'(bus.waiting), 32'd0);
      chk("exec_rf_ra", 32'(bus.rf_ra), 32'(t.ra));
      chk("exec_rf_rb", 32'(bus.rf_rb), 32'(t.rb));
      chk("exec_alu_op", 32'(bus.alu_op), 32'(t.op));
      chk("exec_sel_imm", 32'(bus.sel_imm), 32'(t.imm));
      chk("exec_operand2", 32'(bus.operand2), 32'(t.op2));
      chk("exec_ld_c", 32'(bus.ld_c), 32'(t.ld_c));
      chk("exec_ld_status", 32'(bus.ld_status), 32'(t.ld_status));
      chk("exec_rf_we", 32'(bus.rf_we), 32'd0);
      chk("exec_illegal", 32'(bus.illegal), 32'd0);
      @(negedge clk);
      chk("wb_waiting", 32'(bus.waiting), 32'd0);
      chk("wb_rf_wa", 32'(bus.rf_wa), 32'(t.wa));
      chk("wb_rf_we", 32'(bus.rf_we), 32'(t.we));
      chk("wb_illegal", 32'(bus.illegal), 32'(t.ill));
      chk("wb_ld_c", 32'(bus.ld_c), 32'd0);
      chk("wb_ld_status", 32'(bus.ld_status), 32'd0);
      @(negedge clk);
      if (t.inc) exp_retired++;
      chk("retired", bus.retired, 32'(exp_retired));
      chk("fetch_illegal", 32'(bus.illegal), 32'd0);
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      exp_retired = 0;
      //          instr          flags  ra    rb    wa    op    imm  op2     ldc ls  we  ill inc
      vecs[0]  = '{32'h0000_0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 12'h000, 0, 0, 0, 0, 0};
      vecs[1]  = '{32'hE3A0_0001, 4'h0, 4'h0, 4'h1, 4'h0, 4'hD, 1'b1, 12'h001, 1, 0, 1, 0, 1};
      vecs[2]  = '{32'hE080_0001, 4'h0, 4'h0, 4'h1, 4'h0, 4'h4, 1'b0, 12'h001, 1, 0, 1, 0, 1};
      vecs[3]  = '{32'hE150_0001, 4'h0, 4'h0, 4'h1, 4'h0, 4'hA, 1'b0, 12'h001, 1, 1, 0, 0, 1};
      vecs[4]  = '{32'h03A0_2005, 4'h4, 4'h0, 4'h5, 4'h2, 4'hD, 1'b1, 12'h005, 1, 0, 1, 0, 1};
      vecs[5]  = '{32'h03A0_2005, 4'h0, 4'h0, 4'h5, 4'h2, 4'hD, 1'b1, 12'h005, 0, 0, 0, 0, 0};
      vecs[6]  = '{32'hE590_0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'hC, 1'b0, 12'h000, 0, 0, 0, 1, 0};
      vecs[7]  = '{32'hE3A0_F000, 4'h0, 4'h0, 4'h0, 4'hF, 4'hD, 1'b1, 12'h000, 0, 0, 0, 1, 0};
      vecs[8]  = '{32'hC091_3002, 4'h9, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 12'h002, 1, 1, 1, 0, 1};
      vecs[9]  = '{32'hC091_3002, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 12'h002, 0, 0, 0, 0, 0};
      vecs[10] = '{32'hF3A0_0001, 4'h0, 4'h0, 4'h1, 4'h0, 4'hD, 1'b1, 12'h001, 0, 0, 0, 0, 0};
      vecs[11] = '{32'h93A0_1007, 4'h2, 4'h0, 4'h7, 4'h1, 4'hD, 1'b1, 12'h007, 0, 0, 0, 0, 0};
      vecs[12] = '{32'h83A0_1007, 4'h2, 4'h0, 4'h7, 4'h1, 4'hD, 1'b1, 12'h007, 1, 0, 1, 0, 1};
      vecs[13] = '{32'hE110_F000, 4'h0, 4'h0, 4'h0, 4'hF, 4'h8, 1'b0, 12'h000, 1, 1, 0, 0, 1};
      vecs[14] = '{32'h0C00_0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 12'h000, 0, 0, 0, 1, 0};
      vecs[15] = '{32'hB3A0_4003, 4'h1, 4'h0, 4'h3, 4'h4, 4'hD, 1'b1, 12'h003, 1, 0, 1, 0, 1};

      rst_n     = 1'b0;
      bus.instr = '0;
      bus.flags = '0;
      repeat (3) @(negedge clk);
      chk("rst_waiting", 32'(bus.waiting), 32'd1);
      chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
      chk("rst_ld_c", 32'(bus.ld_c), 32'd0);
      chk("rst_ld_status", 32'(bus.ld_status), 32'd0);
      chk("rst_illegal", 32'(bus.illegal), 32'd0);
      chk("rst_retired", bus.retired, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         run_vec(vecs[i]);
      end

      // Reset asserted mid-EXEC of ADD: no enables, back in FETCH at once.
      bus.instr = 32'hE080_0001;
      bus.flags = 4'h0;
      @(negedge clk);
      chk("abort_exec_ld_c", 32'(bus.ld_c), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_waiting", 32'(bus.waiting), 32'd1);
      chk("abort_ld_c", 32'(bus.ld_c), 32'd0);
      chk("abort_retired", bus.retired, 32'd0);
      exp_retired = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("abort_rf_we", 32'(bus.rf_we), 32'd0);
         chk("abort_hold_waiting", 32'(bus.waiting), 32'd1);
      end
      bus.instr = '0;
      rst_n     = 1'b1;
      // ir was cleared by reset: idle ANDEQ with Z=0 retires nothing.
      run_vec(vecs[0]);
      run_vec(vecs[1]);
      run_vec(vecs[2]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
